// File: rtl/fixdiv_stream_if.sv
// Operand/result stream bundle for fixdiv_stream.
// The master drives operands and out_ready; the slave (divider) drives everything else.
interface fixdiv_stream_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAGW  = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_rnd;
  logic [TAGW-1:0]  in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_val;
  logic [TAGW-1:0]  out_tag;
  logic             out_dbz;
  logic             out_ovf;
  logic             busy;

  modport master (
    output in_valid, in_a, in_b, in_rnd, in_tag, out_ready,
    input  in_ready, out_valid, out_val, out_tag, out_dbz, out_ovf, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_rnd, in_tag, out_ready,
    output in_ready, out_valid, out_val, out_tag, out_dbz, out_ovf, busy
  );
endinterface

// File: rtl/fixdiv_stream.sv
// Signed Q-format restoring divider, one quotient bit per cycle, with rounding,
// saturate/wrap overflow, divide-by-zero flagging and a pass-through tag.
module fixdiv_stream #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FBITS = 16,
  parameter int unsigned TAGW  = 4,
  parameter bit          SAT   = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  fixdiv_stream_if.slave bus
);

  localparam int unsigned N  = WIDTH + FBITS + 1;
  localparam int unsigned AW = WIDTH + 1;
  localparam int unsigned RW = WIDTH + 2;
  localparam int unsigned CW = $clog2(N);

  localparam logic [CW-1:0]    CntLast = CW'(N - 1);
  localparam logic [WIDTH-1:0] ValMax  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] ValMin  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StFin, StDone} state_t;

  state_t r_state;
  state_t w_state_d;

  logic [N-1:0]     r_num;
  logic [N-1:0]     r_q;
  logic [RW-1:0]    r_rem;
  logic [AW-1:0]    r_den;
  logic [CW-1:0]    r_cnt;
  logic             r_neg;
  logic             r_rnd;
  logic             r_dbz;
  logic             r_a_zero;
  logic [TAGW-1:0]  r_tag;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_val;
  logic [TAGW-1:0]  r_out_tag;
  logic             r_out_dbz;
  logic             r_out_ovf;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_b_zero;
  logic [AW-1:0]    w_a_ext;
  logic [AW-1:0]    w_b_ext;
  logic [AW-1:0]    w_abs_a;
  logic [AW-1:0]    w_abs_b;
  logic [RW-1:0]    w_rem_sh;
  logic [RW-1:0]    w_den_ext;
  logic [RW-1:0]    w_diff;
  logic             w_ge;
  logic [N-1:0]     w_mag;
  logic [N-1:0]     w_lim_neg;
  logic [N-1:0]     w_lim;
  logic [N-1:0]     w_sval;
  logic [WIDTH-1:0] w_res_val;
  logic             w_res_ovf;
  logic             w_unused;

  // Operand capture: magnitudes at WIDTH+1 bits so that |MIN| is exact.
  assign w_in_ready = rst_n & ((r_state == StIdle) | ((r_state == StDone) & bus.out_ready));
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_b_zero   = (bus.in_b == '0);
  assign w_a_ext    = {bus.in_a[WIDTH-1], bus.in_a};
  assign w_b_ext    = {bus.in_b[WIDTH-1], bus.in_b};
  assign w_abs_a    = bus.in_a[WIDTH-1] ? (~w_a_ext + AW'(1)) : w_a_ext;
  assign w_abs_b    = bus.in_b[WIDTH-1] ? (~w_b_ext + AW'(1)) : w_b_ext;

  // One restoring step: shift in the next numerator bit, subtract if it fits.
  assign w_rem_sh  = {r_rem[RW-2:0], r_num[N-1]};
  assign w_den_ext = {{(RW-AW){1'b0}}, r_den};
  assign w_ge      = (w_rem_sh >= w_den_ext);
  assign w_diff    = w_rem_sh - w_den_ext;

  // Finalise: drop the guard bit (optionally rounding on it), range-check, apply sign.
  assign w_mag     = {1'b0, r_q[N-1:1]} + {{(N-1){1'b0}}, r_rnd & r_q[0]};
  assign w_lim_neg = {{(N-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
  assign w_lim     = r_neg ? w_lim_neg : (w_lim_neg - N'(1));
  assign w_sval    = r_neg ? (~w_mag + N'(1)) : w_mag;
  assign w_unused  = ^{w_abs_a[WIDTH], w_sval[N-1:WIDTH]};

  always_comb begin
    w_res_val = '0;
    w_res_ovf = 1'b0;
    if (r_dbz) begin
      w_res_val = r_a_zero ? '0 : (r_neg ? ValMin : ValMax);
    end else if (w_mag > w_lim) begin
      w_res_ovf = 1'b1;
      w_res_val = SAT ? (r_neg ? ValMin : ValMax) : w_sval[WIDTH-1:0];
    end else begin
      w_res_val = w_sval[WIDTH-1:0];
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (w_accept) w_state_d = w_b_zero ? StFin : StCalc;
      end
      StCalc: begin
        if (r_cnt == CntLast) w_state_d = StFin;
      end
      StFin: begin
        w_state_d = StDone;
      end
      StDone: begin
        if (bus.out_ready) begin
          if (w_accept) w_state_d = w_b_zero ? StFin : StCalc;
          else          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num    <= '0;
      r_q      <= '0;
      r_rem    <= '0;
      r_den    <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_rnd    <= 1'b0;
      r_dbz    <= 1'b0;
      r_a_zero <= 1'b0;
      r_tag    <= '0;
    end else if (w_accept) begin
      r_num    <= {w_abs_a[WIDTH-1:0], {(FBITS+1){1'b0}}};
      r_q      <= '0;
      r_rem    <= '0;
      r_den    <= w_abs_b;
      r_cnt    <= '0;
      r_neg    <= bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1];
      r_rnd    <= bus.in_rnd;
      r_dbz    <= w_b_zero;
      r_a_zero <= (bus.in_a == '0);
      r_tag    <= bus.in_tag;
    end else if (r_state == StCalc) begin
      r_num <= {r_num[N-2:0], 1'b0};
      r_q   <= {r_q[N-2:0], w_ge};
      r_rem <= w_ge ? w_diff : w_rem_sh;
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // A divide-by-zero accepted on the consuming edge keeps out_valid high into FIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_val   <= '0;
      r_out_tag   <= '0;
      r_out_dbz   <= 1'b0;
      r_out_ovf   <= 1'b0;
    end else if (r_state == StFin) begin
      r_out_valid <= 1'b1;
      r_out_val   <= w_res_val;
      r_out_tag   <= r_tag;
      r_out_dbz   <= r_dbz;
      r_out_ovf   <= w_res_ovf;
    end else if ((r_state == StDone) && bus.out_ready && !(w_accept && w_b_zero)) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_val   = r_out_val;
  assign bus.out_tag   = r_out_tag;
  assign bus.out_dbz   = r_out_dbz;
  assign bus.out_ovf   = r_out_ovf;
  assign bus.busy      = (r_state == StCalc) | (r_state == StFin);

endmodule

// File: tb/tb_fixdiv_stream.sv
// Directed-vector bench for fixdiv_stream; a SAT=0 twin runs the same stimulus
// so the wrap result can be checked alongside the saturating one.
module tb_fixdiv_stream;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned FBITS = 16;
  localparam int unsigned TAGW  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic             in_valid  = 1'b0;
  logic             in_rnd    = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] in_a      = '0;
  logic [WIDTH-1:0] in_b      = '0;
  logic [TAGW-1:0]  in_tag    = '0;

  fixdiv_stream_if #(.WIDTH(WIDTH), .TAGW(TAGW)) bus_s ();
  fixdiv_stream_if #(.WIDTH(WIDTH), .TAGW(TAGW)) bus_w ();

  assign bus_s.in_valid  = in_valid;
  assign bus_s.in_a      = in_a;
  assign bus_s.in_b      = in_b;
  assign bus_s.in_rnd    = in_rnd;
  assign bus_s.in_tag    = in_tag;
  assign bus_s.out_ready = out_ready;
  assign bus_w.in_valid  = in_valid;
  assign bus_w.in_a      = in_a;
  assign bus_w.in_b      = in_b;
  assign bus_w.in_rnd    = in_rnd;
  assign bus_w.in_tag    = in_tag;
  assign bus_w.out_ready = out_ready;

  fixdiv_stream #(.WIDTH(WIDTH), .FBITS(FBITS), .TAGW(TAGW), .SAT(1'b1)) u_dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  fixdiv_stream #(.WIDTH(WIDTH), .FBITS(FBITS), .TAGW(TAGW), .SAT(1'b0)) u_dut_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_w)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for out_valid and checks the held result; latency counts edges.
  task automatic check_result(input string name, input logic [31:0] exp_val,
                              input logic [3:0] exp_tag, input logic exp_dbz,
                              input logic exp_ovf, input int exp_lat);
    int cyc = 0;
    while (!bus_s.out_valid && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq({name, ".lat"}, 64'(cyc), 64'(exp_lat));
    check_eq({name, ".val"}, 64'(bus_s.out_val), 64'(exp_val));
    check_eq({name, ".tag"}, 64'(bus_s.out_tag), 64'(exp_tag));
    check_eq({name, ".dbz"}, 64'(bus_s.out_dbz), 64'(exp_dbz));
    check_eq({name, ".ovf"}, 64'(bus_s.out_ovf), 64'(exp_ovf));
  endtask

  task automatic start_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic rnd, input logic [3:0] tag);
    in_a     = a;
    in_b     = b;
    in_rnd   = rnd;
    in_tag   = tag;
    in_valid = 1'b1;
    #1;
    check_eq({name, ".in_ready"}, 64'(bus_s.in_ready), 64'd1);
    @(posedge clk);
    #1;
    // Scramble inputs after accept; the operation must not see them.
    in_valid = 1'b0;
    in_a     = ~a;
    in_b     = ~b;
    in_rnd   = ~rnd;
    in_tag   = ~tag;
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic rnd, input logic [3:0] tag, input logic [31:0] exp_val,
                        input logic exp_dbz, input logic exp_ovf, input int exp_lat);
    start_op(name, a, b, rnd, tag);
    check_result(name, exp_val, tag, exp_dbz, exp_ovf, exp_lat);
  endtask

  task automatic consume(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq({name, ".consumed"}, 64'(bus_s.out_valid), 64'd0);
  endtask

  initial begin
    int bad;
    logic [31:0] held_val;

    #2 rst_n = 1'b0;
    #1;
    check_eq("rst.out_valid", 64'(bus_s.out_valid), 64'd0);
    check_eq("rst.in_ready", 64'(bus_s.in_ready), 64'd0);
    check_eq("rst.busy", 64'(bus_s.busy), 64'd0);
    check_eq("rst.out_val", 64'(bus_s.out_val), 64'd0);
    #19 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 100/2 with all four sign combinations
    run_op("pp", 32'h0064_0000, 32'h0002_0000, 1'b0, 4'h1, 32'h0032_0000, 1'b0, 1'b0, 50);
    consume("pp");
    run_op("np", 32'hFF9C_0000, 32'h0002_0000, 1'b0, 4'h2, 32'hFFCE_0000, 1'b0, 1'b0, 50);
    consume("np");
    run_op("pn", 32'h0064_0000, 32'hFFFE_0000, 1'b0, 4'h3, 32'hFFCE_0000, 1'b0, 1'b0, 50);
    consume("pn");
    run_op("nn", 32'hFF9C_0000, 32'hFFFE_0000, 1'b0, 4'h4, 32'h0032_0000, 1'b0, 1'b0, 50);
    consume("nn");

    // Rounding
    run_op("r23t", 32'h0002_0000, 32'h0003_0000, 1'b0, 4'h6, 32'h0000_AAAA, 1'b0, 1'b0, 50);
    consume("r23t");
    run_op("r23r", 32'h0002_0000, 32'h0003_0000, 1'b1, 4'h7, 32'h0000_AAAB, 1'b0, 1'b0, 50);
    consume("r23r");
    run_op("rn23", 32'hFFFE_0000, 32'h0003_0000, 1'b1, 4'h8, 32'hFFFF_5555, 1'b0, 1'b0, 50);
    consume("rn23");
    run_op("r13r", 32'h0001_0000, 32'h0003_0000, 1'b1, 4'h9, 32'h0000_5555, 1'b0, 1'b0, 50);
    consume("r13r");
    run_op("zneg", 32'h0000_0000, 32'hFFFF_0000, 1'b1, 4'hA, 32'h0000_0000, 1'b0, 1'b0, 50);
    consume("zneg");

    // Overflow and the exact-MIN boundary
    run_op("ovf", 32'h7FFF_0000, 32'h0000_8000, 1'b0, 4'hB, 32'h7FFF_FFFF, 1'b0, 1'b1, 50);
    check_eq("ovf.wrap.val", 64'(bus_w.out_val), 64'h0000_0000_FFFE_0000);
    check_eq("ovf.wrap.ovf", 64'(bus_w.out_ovf), 64'd1);
    consume("ovf");
    run_op("minm1", 32'h8000_0000, 32'hFFFF_0000, 1'b0, 4'hC, 32'h7FFF_FFFF, 1'b0, 1'b1, 50);
    consume("minm1");
    run_op("minp1", 32'h8000_0000, 32'h0001_0000, 1'b0, 4'hD, 32'h8000_0000, 1'b0, 1'b0, 50);
    consume("minp1");

    // Divide by zero
    run_op("dbzp", 32'h0001_E240, 32'h0000_0000, 1'b0, 4'hE, 32'h7FFF_FFFF, 1'b1, 1'b0, 1);
    consume("dbzp");
    run_op("dbzn", 32'hFFFE_1DC0, 32'h0000_0000, 1'b0, 4'hF, 32'h8000_0000, 1'b1, 1'b0, 1);
    consume("dbzn");
    run_op("dbz0", 32'h0000_0000, 32'h0000_0000, 1'b1, 4'h0, 32'h0000_0000, 1'b1, 1'b0, 1);
    consume("dbz0");

    // Backpressure: hold 20 cycles while a new request waits, then consume+accept together
    run_op("bp", 32'h0002_0000, 32'h0003_0000, 1'b0, 4'h2, 32'h0000_AAAA, 1'b0, 1'b0, 50);
    held_val = bus_s.out_val;
    in_a     = 32'h0064_0000;
    in_b     = 32'h0002_0000;
    in_rnd   = 1'b0;
    in_tag   = 4'h5;
    in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (!bus_s.out_valid || bus_s.in_ready || bus_s.out_val !== held_val ||
          bus_s.out_tag !== 4'h2 || bus_s.busy)
        bad++;
    end
    check_eq("bp.stable", 64'(bad), 64'd0);
    out_ready = 1'b1;
    #1;
    check_eq("bp.in_ready", 64'(bus_s.in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_eq("bp.consumed", 64'(bus_s.out_valid), 64'd0);
    check_eq("bp.busy", 64'(bus_s.busy), 64'd1);
    check_result("tag5", 32'h0032_0000, 4'h5, 1'b0, 1'b0, 50);
    consume("tag5");

    // Reset mid-CALC
    start_op("rst", 32'h0064_0000, 32'h0002_0000, 1'b0, 4'h9);
    repeat (10) @(posedge clk);
    #1;
    check_eq("rst.calc_busy", 64'(bus_s.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rstm.out_valid", 64'(bus_s.out_valid), 64'd0);
    check_eq("rstm.out_val", 64'(bus_s.out_val), 64'd0);
    check_eq("rstm.out_tag", 64'(bus_s.out_tag), 64'd0);
    check_eq("rstm.busy", 64'(bus_s.busy), 64'd0);
    check_eq("rstm.in_ready", 64'(bus_s.in_ready), 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rstr.in_ready", 64'(bus_s.in_ready), 64'd1);
    check_eq("rstr.out_valid", 64'(bus_s.out_valid), 64'd0);
    run_op("post", 32'h0064_0000, 32'h0002_0000, 1'b0, 4'h3, 32'h0032_0000, 1'b0, 1'b0, 50);
    consume("post");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
